// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: MDU op encodings, FSM states and op-class helpers.
// MDU_MADD_EN adds madd/maddu to the multi-cycle multiply class.
package mdu_ctrl_pkg;
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic logic is_div(input logic [3:0] op);
    return op == MDU_DIV || op == MDU_DIVU;
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op == MDU_MULT || op == MDU_MULTU || op == MDU_MADD || op == MDU_MADDU;
`else
    return op == MDU_MULT || op == MDU_MULTU;
`endif
  endfunction
endpackage

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith: combinational 64-bit MDU result {hi,lo} and divide-by-zero flag.
// MDU_MADD_EN adds the {hi,lo} accumulate adder for madd/maddu.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  mdop,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div_by_zero
);
  logic        sgn_mul, neg_a, neg_b;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] mag_a, mag_b, uq, ur, q, r;
  assign sgn_mul = mdop == MDU_MULT || mdop == MDU_MADD;
  assign ext_a = {{32{sgn_mul & src_a[31]}}, src_a};
  assign ext_b = {{32{sgn_mul & src_b[31]}}, src_b};
  assign prod = ext_a * ext_b;
  // One unsigned divider on magnitudes; signs restored afterwards so that
  // 0x80000000 / -1 wraps cleanly instead of overflowing a signed divide.
  assign neg_a = mdop == MDU_DIV && src_a[31];
  assign neg_b = mdop == MDU_DIV && src_b[31];
  assign mag_a = neg_a ? -src_a : src_a;
  assign mag_b = neg_b ? -src_b : src_b;
  assign div_by_zero = is_div(mdop) && src_b == '0;
  assign uq = div_by_zero ? '0 : mag_a / mag_b;
  assign ur = div_by_zero ? '0 : mag_a % mag_b;
  assign q = (neg_a ^ neg_b) ? -uq : uq;
  assign r = neg_a ? -ur : ur;
`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo} + prod;
  assign res = is_div(mdop) ? {r, q} : (mdop == MDU_MADD || mdop == MDU_MADDU) ? acc : prod;
`else
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
  assign res = is_div(mdop) ? {r, q} : prod;
`endif
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller owning HI/LO with busy-counter latency.
// MDU_MADD_EN enables madd/maddu (mdop 7/8); otherwise they are nops.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_use,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_req
);
  state_e      state, state_n;
  logic [4:0]  cnt;
  logic [63:0] res, res_q;
  logic        dbz, launch;
  mdu_arith u_arith (
    .mdop(mdop), .src_a(src_a), .src_b(src_b), .hi(hi), .lo(lo),
    .res(res), .div_by_zero(dbz)
  );
  assign launch = start & (is_mul(mdop) | is_div(mdop)) & ~dbz;
  assign busy = state == BUSY;
  assign stall_req = d_md_use & (busy | launch);
  always_comb state_n = busy ? (cnt == 5'd1 ? IDLE : BUSY) : (launch ? BUSY : IDLE);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Starts arriving while busy are ignored: the hazard unit keeps them out.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      res_q <= '0;
      hi <= '0;
      lo <= '0;
    end else if (busy) begin
      cnt <= cnt - 5'd1;
      if (cnt == 5'd1) {hi, lo} <= res_q;
    end else if (launch) begin
      res_q <= res;
      cnt <= is_div(mdop) ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
    end else if (start && mdop == MDU_MTHI) hi <= src_a;
    else if (start && mdop == MDU_MTLO) lo <= src_a;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table-driven scoreboard bench for mdu_ctrl plus hand-written corner sequences.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;
  logic clk = 0, reset, start, d_md_use, busy, stall_req;
  logic [3:0] mdop;
  logic [31:0] src_a, src_b, hi, lo;
  int checks = 0, errors = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    int          cyc;
    logic [31:0] eh, el;
    string       nm;
  } vec_t;
  vec_t v[$];

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .src_a(src_a), .src_b(src_b),
    .d_md_use(d_md_use), .busy(busy), .hi(hi), .lo(lo), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (start && busy) begin
      errors++;
      $display("FAIL start_while_busy: start=1 busy=1 required start=0 while busy");
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t t);
    int n = 0;
    @(negedge clk);
    mdop = t.op; src_a = t.a; src_b = t.b; start = 1;
    sb.push_back({t.eh, t.el});
    @(negedge clk);
    start = 0; mdop = MDU_NONE;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({t.nm, "_busy_cycles"}, 64'(n), 64'(t.cyc));
    chk({t.nm, "_hilo"}, {hi, lo}, sb.pop_front());
  endtask

  initial begin
    int n, ns;
`ifdef MDU_MADD_EN
    localparam int MC = 5;
`else
    localparam int MC = 0;
`endif
    reset = 1; start = 0; d_md_use = 0; mdop = MDU_NONE; src_a = 0; src_b = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_hilo", {hi, lo}, 0);
    chk("reset_stall", 64'(stall_req), 0);
    d_md_use = 1;
    #1 chk("reset_stall_use_idle", 64'(stall_req), 0);
    d_md_use = 0;
    @(negedge clk);
    reset = 0;

    v.push_back('{MDU_MULT,  32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7"});
    v.push_back('{MDU_DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14,       "divu_100_7"});
    v.push_back('{MDU_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"});
    v.push_back('{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000, "div_ovf"});
    v.push_back('{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, "multu_max"});
    v.push_back('{MDU_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h0,        "mult_min"});
    v.push_back('{MDU_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD, "div_7_m2"});
    v.push_back('{MDU_DIVU,  32'd5,        32'd0,        0,  32'd1,        32'hFFFFFFFD, "divu_by0"});
    v.push_back('{MDU_DIV,   32'd5,        32'd0,        0,  32'd1,        32'hFFFFFFFD, "div_by0"});
    v.push_back('{MDU_NONE,  32'd9,        32'd9,        0,  32'd1,        32'hFFFFFFFD, "nop"});
    v.push_back('{4'd15,     32'd9,        32'd9,        0,  32'd1,        32'hFFFFFFFD, "undef_op"});
    v.push_back('{MDU_MTHI,  32'd0,        32'd3,        0,  32'd0,        32'hFFFFFFFD, "mthi_0"});
    v.push_back('{MDU_MTLO,  32'hFFFFFFFF, 32'd3,        0,  32'd0,        32'hFFFFFFFF, "mtlo_ones"});
`ifdef MDU_MADD_EN
    v.push_back('{MDU_MADDU, 32'd1,        32'd1,        MC, 32'd1,        32'd0,        "maddu_1x1"});
`else
    v.push_back('{MDU_MADDU, 32'd1,        32'd1,        MC, 32'd0,        32'hFFFFFFFF, "maddu_1x1"});
`endif
    v.push_back('{MDU_MADD,  32'hFFFFFFFF, 32'd1,        MC, 32'd0,        32'hFFFFFFFF, "madd_m1x1"});
    foreach (v[i]) run_op(v[i]);

    @(negedge clk);
    mdop = MDU_MTHI; src_a = 32'h12345678; start = 1;
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'h12345678);
    chk("mthi_busy", 64'(busy), 0);
    mdop = MDU_MTLO; src_a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 0; mdop = MDU_NONE;
    chk("mtlo_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
    chk("mtlo_busy", 64'(busy), 0);

    @(negedge clk);
    d_md_use = 1; mdop = MDU_MULT; src_a = 3; src_b = 3; start = 1;
    #1 ns = stall_req ? 1 : 0;
    n = 0;
    @(negedge clk);
    start = 0; mdop = MDU_NONE;
    while (busy && n < 40) begin
      n++;
      if (stall_req) ns++;
      @(negedge clk);
    end
    chk("stall_cycles", 64'(ns), 6);
    chk("stall_low_after", 64'(stall_req), 0);
    chk("mult_3x3", {hi, lo}, 64'd9);
    mdop = MDU_DIV; src_a = 5; src_b = 0; start = 1;
    #1 chk("stall_div_by0", 64'(stall_req), 0);
    @(negedge clk);
    start = 0; mdop = MDU_NONE; d_md_use = 0;
    chk("div_by0_busy", 64'(busy), 0);
    chk("div_by0_hilo", {hi, lo}, 64'd9);

    mdop = MDU_DIV; src_a = 100; src_b = 7; start = 1;
    @(negedge clk);
    start = 0; mdop = MDU_NONE;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 1);
    reset = 1;
    #1 chk("midbusy_reset_busy", 64'(busy), 0);
    chk("midbusy_reset_hilo", {hi, lo}, 0);
    @(negedge clk);
    reset = 0;
    run_op('{MDU_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'd1, 32'hFFFFFFFE, "multu_after_reset"});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the E stage of the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo (and optionally madd/maddu) from E, models multi-cycle latency with a busy counter, and owns the architectural HI/LO registers. It also raises a stall request to the hazard unit whenever an MDU-class instruction sits in D while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage instruction is MDU-class and valid this cycle
- mdop  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu
- src_a  in  32  forwarded rs value
- src_b  in  32  forwarded rt value
- d_md_use  in  1  D-stage instruction reads or writes HI/LO (including mfhi/mflo)
- busy  out  1  multi-cycle operation in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- stall_req  out  1  to hazard unit; OR-ed into the global stall

## Operation
- States: IDLE, BUSY. A 5-bit down-counter cnt is active in BUSY.
- IDLE + start + mdop∈{1,2,3,4,7,8}: latch the 64-bit result into res_hi/res_lo, load cnt with MULT_CYCLES or DIV_CYCLES, go to BUSY.
- IDLE + start + mdop=5: hi←src_a at the edge, no BUSY. mdop=6: lo←src_a likewise.
- BUSY: cnt decrements each edge; when cnt==1 at an edge, hi/lo←res_hi/res_lo and return to IDLE.
- start while BUSY is ignored; the hazard unit guarantees this never happens, and the bench asserts it.
- mdop=0, or an undefined code with start=1: no effect.
- Arithmetic: mult = signed 32×32→64; multu = unsigned. div: lo=quotient, hi=remainder, truncating toward zero, remainder takes the sign of the dividend; divu unsigned.
- Divide by zero (src_b==0): no BUSY and no HI/LO change, treated as nop.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- madd/maddu: {hi,lo} + product (signed/unsigned), mod 2^64, using the HI/LO values at start.
- busy = (state==BUSY).
- stall_req = d_md_use & (busy | (start & mdop∈{1,2,3,4,7,8} & ~div_by_zero)).

## Timing
- Reset values: busy=0, hi=0, lo=0, stall_req depends only on inputs (0 when d_md_use=0), state=IDLE, cnt=0.
- start sampled at edge k: busy=1 during cycles k+1 … k+N (N = MULT_CYCLES or DIV_CYCLES).
- New hi/lo are visible from cycle k+N+1, the same cycle busy falls.
- mthi/mtlo at edge k: hi/lo are updated in cycle k+1; busy stays 0.
- A new start is accepted in the first cycle busy=0, so back-to-back multi-cycle ops can run with no gap.
- reset asserted mid-BUSY: immediately IDLE, cnt=0, hi=lo=0, pending result discarded.
- hi/lo are registered outputs; mfhi/mflo read them combinationally in E.

## Configuration
- MDU_MADD_EN defined: mdop 7/8 are implemented as above, using MULT_CYCLES latency.
- Not defined: mdop 7/8 are treated as undefined (nop, no BUSY); the accumulate adder is not synthesized.

## Structure
- const.v holds the MDU_* mdop encodings beside the existing instruction-type constants, for use by the Decoder and the hazard unit.
- One combinational sub-module, mdu_arith, produces the 64-bit result and the div_by_zero flag from mdop, src_a, src_b, hi and lo.
- mdu_ctrl keeps the FSM, counter, HI/LO registers and stall logic.

## Test plan
- mult −3 × 7 (0xFFFFFFFD, 7), defaults → busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- divu 100 / 7 → busy for 10 cycles; then lo=14, hi=2. div −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles → busy never rises; hi and lo match 1 cycle after each.
- d_md_use=1 in the start cycle of mult and during BUSY → stall_req high for 6 cycles, low when busy falls; div by zero → no stall, hi/lo unchanged.
- reset pulsed at the 3rd busy cycle of div → busy=0 and hi=lo=0 immediately; a subsequent multu 0xFFFFFFFF × 2 → hi=1, lo=0xFFFFFFFE.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu 1×1 → hi=1, lo=0 after 5 cycles. Without it: hi/lo unchanged, busy stays 0.
